// File: rtl/spi_block_xfer_pkg.sv
// Shared definitions for the SPI block sequencer and the AES datapath it serves.
package spi_block_xfer_pkg;

    localparam int BYTE_W        = 8;
    localparam int AES_BLK_W     = 128;
    localparam int AES_NUM_BYTES = AES_BLK_W / BYTE_W;

    // Sequencer states: accept a block, request a byte, wait for it, idle gap, hold result.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } state_e;

endpackage

// File: rtl/spi_block_xfer_if.sv
// Bundles the block-in, result-out and byte-engine handshakes of the sequencer.
// slave  : the sequencer itself.
// master : everything around it (cipher datapath, AES core, SPI byte engine).
interface spi_block_xfer_if
    import spi_block_xfer_pkg::*;
#(
    parameter int NUM_BYTES = AES_NUM_BYTES
) ();

    localparam int BLK_W = BYTE_W * NUM_BYTES;

    logic              blk_valid;
    logic              blk_ready;
    logic [BLK_W-1:0]  blk_data;
    logic              res_valid;
    logic              res_ready;
    logic [BLK_W-1:0]  res_data;
    logic              err;
    logic              byte_start;
    logic [BYTE_W-1:0] byte_tx;
    logic [BYTE_W-1:0] byte_rx;
    logic              byte_done;

    modport slave (
        input  blk_valid, blk_data, res_ready, byte_rx, byte_done,
        output blk_ready, res_valid, res_data, err, byte_start, byte_tx
    );

    modport master (
        output blk_valid, blk_data, res_ready, byte_rx, byte_done,
        input  blk_ready, res_valid, res_data, err, byte_start, byte_tx
    );

endinterface

// File: rtl/spi_xfer_timer.sv
// Loadable saturating down-counter shared by the inter-byte gap and the
// per-byte timeout watchdog. Loading GAP_CYCLES-1 (or TIMEOUT_CYCLES-1) and
// counting one step per cycle makes 'expired' rise in the last cycle of the
// interval being measured.
module spi_xfer_timer #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load_gap,
    input  logic load_tmo,
    input  logic count_en,
    output logic expired
);

    localparam int MAX_LOAD = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W    = (MAX_LOAD < 1) ? 1 : $clog2(MAX_LOAD + 1);

    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: a load wins over counting; counting stops at zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_d = count_q;
        if (load_tmo) begin
            count_d = TMO_LOAD;
        end else if (load_gap) begin
            count_d = GAP_LOAD;
        end else if (count_en && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every flop samples pre-edge values regardless of block order.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/spi_block_xfer.sv
// Block sequencer: takes one AES block, pushes it MSB byte first through the
// single-byte SPI engine handshake, reassembles the returned bytes into a
// result block, spaces bytes by GAP_CYCLES and aborts a stalled byte after
// TIMEOUT_CYCLES.
module spi_block_xfer
    import spi_block_xfer_pkg::*;
#(
    parameter int NUM_BYTES      = AES_NUM_BYTES,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    spi_block_xfer_if.slave   bus
);

    localparam int              BLK_W    = BYTE_W * NUM_BYTES;
    localparam int              IDX_W    = $clog2(NUM_BYTES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_e           state_q, state_d;
    logic [BLK_W-1:0] shreg_q, shreg_d;
    logic [BLK_W-1:0] res_q,   res_d;
    logic [IDX_W-1:0] idx_q,   idx_d;

    logic tmr_load_gap;
    logic tmr_load_tmo;
    logic tmr_count_en;
    logic tmr_expired;
    logic last_byte;

    assign last_byte = (idx_q == LAST_IDX);

    // Timer control: arm the watchdog while requesting a byte, arm the gap on a
    // non-final byte_done, and count down while waiting or gapping.
    always_comb begin
        tmr_load_tmo = (state_q == ST_START);
        tmr_load_gap = (state_q == ST_WAIT) && bus.byte_done && !last_byte && (GAP_CYCLES != 0);
        tmr_count_en = (state_q == ST_WAIT) || (state_q == ST_GAP);
    end

    spi_xfer_timer #(
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_gap (tmr_load_gap),
        .load_tmo (tmr_load_tmo),
        .count_en (tmr_count_en),
        .expired  (tmr_expired)
    );

    // Next-state and datapath updates; byte_done is only honoured in WAIT and
    // beats a simultaneous watchdog expiry.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        res_d   = res_q;
        idx_d   = idx_q;

        unique case (state_q)
            ST_IDLE: begin
                // blk_ready is high throughout IDLE, so blk_valid alone is the handshake.
                if (bus.blk_valid) begin
                    shreg_d = bus.blk_data;
                    res_d   = '0;
                    idx_d   = '0;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (bus.byte_done) begin
                    for (int s = 0; s < NUM_BYTES; s++) begin
                        if (idx_q == IDX_W'(s)) begin
                            res_d[BLK_W-1-s*BYTE_W -: BYTE_W] = bus.byte_rx;
                        end
                    end
                    shreg_d = shreg_q << BYTE_W;
                    idx_d   = idx_q + IDX_W'(1);
                    if (last_byte) begin
                        state_d = ST_DONE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (tmr_expired) begin
                    // Partial result is abandoned; res_valid never rises for this block.
                    state_d = ST_IDLE;
                end
            end

            ST_GAP: begin
                if (tmr_expired) begin
                    state_d = ST_START;
                end
            end

            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shift register, result and index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data registers are reset too because res_data is visible and must read 0 out of reset.
            state_q <= ST_IDLE;
            shreg_q <= '0;
            res_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
        end
    end

    // Moore outputs decoded from the state; err is the single WAIT cycle in
    // which the watchdog expires without a completing byte_done.
    always_comb begin
        bus.blk_ready  = (state_q == ST_IDLE);
        bus.res_valid  = (state_q == ST_DONE);
        bus.res_data   = res_q;
        bus.byte_start = (state_q == ST_START);
        bus.byte_tx    = ((state_q == ST_START) || (state_q == ST_WAIT))
                         ? shreg_q[BLK_W-1 -: BYTE_W] : '0;
        bus.err        = (state_q == ST_WAIT) && tmr_expired && !bus.byte_done;
    end

endmodule

// File: doc/spi_block_xfer.md
Name: spi_block_xfer

Overview:
- Upstream sequencer for the byte-level SPI main engine.
- Accepts one 128-bit AES block from the cipher datapath and issues NUM_BYTES single-byte transfers through the engine's start/tx/done handshake, MSB byte first.
- Assembles the returned rx bytes into a 128-bit result for the AES core.
- Adds a programmable inter-byte gap and a per-byte timeout watchdog.

Parameters:
- NUM_BYTES, 16, bytes per block; block width = 8*NUM_BYTES.
- GAP_CYCLES, 2, idle clk cycles between byte_done and the next byte_start (0 allowed).
- TIMEOUT_CYCLES, 1024, max clk cycles from byte_start to byte_done before abort.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- blk_valid  in  1  input block present.
- blk_ready  out  1  sequencer can accept a block.
- blk_data  in  8*NUM_BYTES  plaintext/ciphertext block to transmit.
- res_valid  out  1  received block available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  8*NUM_BYTES  received block.
- err  out  1  one-cycle pulse on timeout abort.
- byte_start  out  1  one-cycle request to the SPI main engine.
- byte_tx  out  8  byte to send; stable from byte_start until byte_done.
- byte_rx  in  8  byte received; valid in the cycle byte_done=1.
- byte_done  in  1  one-cycle completion pulse from the engine.

Behaviour:
- Reset values: blk_ready=1, res_valid=0, res_data=0, err=0, byte_start=0, byte_tx=0. Internal counters are 0 and the FSM is in IDLE.
- Reset mid-transfer aborts immediately. No byte_start is issued in the cycle after rst deasserts.
- FSM states:
  - IDLE: blk_ready=1. On blk_valid&blk_ready, capture blk_data into the shift register, set idx=0 and go to START.
  - START: drive byte_start=1 for exactly one cycle with byte_tx=shreg[top byte]. Clear the timeout counter and go to WAIT.
  - WAIT: wait for byte_done.
    - On byte_done: write byte_rx into result slot idx (slot 0 = bits [8*NUM_BYTES-1 -: 8]), shift tx left by 8 and increment idx.
    - If idx was NUM_BYTES-1, go to DONE. Otherwise go to GAP, or to START if GAP_CYCLES=0.
    - If the timeout counter reaches TIMEOUT_CYCLES-1 without byte_done: pulse err for one cycle, discard the partial result and go to IDLE.
  - GAP: count GAP_CYCLES cycles, then go to START.
  - DONE: res_valid=1, res_data stable. On res_valid&res_ready, go to IDLE next cycle.
- blk_ready is 0 in every state except IDLE. A new block cannot be accepted while a result is pending (no overlap).
- Latency: byte_start for byte 0 asserts 1 cycle after block acceptance. Byte k+1 starts GAP_CYCLES+1 cycles after byte_done of byte k.
- byte_done is ignored in IDLE, START, GAP and DONE. A byte_done coincident with timeout expiry counts as success (done wins).
- byte_tx holds its value through WAIT. It is 0 in IDLE.
- res_data updates only on byte_done writes. It is cleared on acceptance of a new block.
- idx is ceil(log2(NUM_BYTES))+1 bits wide and never wraps within a block. The timeout counter saturates.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, START, WAIT, GAP, DONE);
  - the BYTE_W=8 constant;
  - the AES_BLK_W=128 constant, shared with the AES core.
- One natural sub-module, spi_xfer_timer. It is a loadable down-counter used both for the GAP countdown and for the timeout watchdog, with separate load values and an expiry flag.
- The FSM and data shift logic stay in the top.

Test Plan:
- Loopback: blk_data=128'h00112233445566778899AABBCCDDEEFF, engine model echoes byte_tx as byte_rx after 20 cycles -> 16 byte_start pulses with tx 00,11,…,FF in order, res_data equals blk_data, res_valid held until res_ready.
- Gap timing: GAP_CYCLES=3 -> exactly 4 cycles between each byte_done and the next byte_start; GAP_CYCLES=0 -> 1 cycle.
- Timeout: engine never returns byte_done on byte 5, TIMEOUT_CYCLES=64 -> err pulses once 64 cycles after byte 5's byte_start, blk_ready=1 next cycle, res_valid never asserts.
- Backpressure: hold res_ready=0 for 50 cycles after completion, present a second blk_valid -> blk_ready stays 0, no byte_start, res_data stable; on res_ready=1 the second block is accepted afterwards.
- Reset mid-operation: assert rst during WAIT of byte 9 -> all outputs at reset values next cycle; a stray byte_done afterwards is ignored.
- Spurious done: byte_done pulses in IDLE and in GAP -> no state change, no result write.
